spi_slave_core: RTL
===================

Name: spi_slave_core

Overview:
Synthesizable SPI slave that sits directly downstream of the SPI master. It consumes the master's SCLK, MOSI and slave-select and drives MISO back. All SPI pins are oversampled in the local system clock domain. Received bytes go to a parallel RX port with a valid pulse, and TX bytes are taken from a one-deep holding buffer. All four CPOL/CPHA modes are supported, with LSB-first bit order to match the master's shift direction.

Parameters:
DATA_W, 8, bits per SPI word
SYNC_STAGES, 2, flip-flop stages on SCLK_IN/SS_IN/MOSI_IN (minimum 2)

Ports:
CLK  in  1  system clock; frequency must be at least 8x SCLK
RST  in  1  reset, asynchronous, active-high
CPOL_IN  in  1  SCLK idle level; latched at frame start
CPHA_IN  in  1  0: sample on leading edge; 1: sample on trailing edge; latched at frame start
SCLK_IN  in  1  SPI clock from master (asynchronous)
SS_IN  in  1  slave select, active-low (asynchronous)
MOSI_IN  in  1  serial data from master (asynchronous)
TX_DATA  in  DATA_W  next word to transmit
TX_LOAD  in  1  1-cycle strobe; writes TX_DATA into the holding register
TX_READY  out  1  holding register empty
MISO  out  1  serial data to master
MISO_OE  out  1  1 while the frame is active; MISO is tristated externally when 0
RX_DATA  out  DATA_W  last complete received word
RX_VALID  out  1  1-cycle pulse when RX_DATA updates
BUSY  out  1  frame active
FRAME_ERR  out  1  1-cycle pulse when SS rises mid-word
TX_UNDERRUN  out  1  1-cycle pulse when a word load finds the holding register empty

Behaviour:
- Reset values: MISO=1, MISO_OE=0, RX_DATA=0, RX_VALID=0, BUSY=0, FRAME_ERR=0, TX_UNDERRUN=0, TX_READY=1. Shift registers, bit counter and the hold-valid flag are cleared. FSM goes to IDLE.
- Synchronizer: SCLK/SS/MOSI pass through SYNC_STAGES FFs, then a 1-FF edge detector. A pin edge is acted on SYNC_STAGES+1 CLK cycles later.
- Leading edge is the SCLK transition away from CPOL; trailing edge is the transition back to CPOL.
  - Sample edge is leading when CPHA=0, trailing when CPHA=1.
  - Shift edge is the other one.
- FSM IDLE:
  - MISO=1, MISO_OE=0, BUSY=0.
  - On synced SS falling: latch CPOL/CPHA, set bit_cnt=0, go to ACTIVE.
  - If CPHA=0, also perform a word load in the same cycle.
- FSM ACTIVE:
  - BUSY=1, MISO_OE=1, MISO=tx_sr[0].
  - On a sample edge: rx_sr={MOSI,rx_sr[DATA_W-1:1]} and bit_cnt++.
  - When bit_cnt reaches DATA_W: RX_DATA<=next rx_sr, RX_VALID pulses for 1 cycle, bit_cnt wraps to 0.
  - On a shift edge with bit_cnt==0 and the edge not being the last trailing edge: perform a word load (CPHA=1 first/next word, CPHA=0 next word).
  - On any other shift edge: tx_sr={1'b1,tx_sr[DATA_W-1:1]}.
- Word load:
  - Hold valid: tx_sr<=hold, hold cleared, TX_READY=1.
  - Hold empty: tx_sr<=all-ones, TX_UNDERRUN pulses.
- Synced SS rising in ACTIVE:
  - Go to IDLE.
  - If bit_cnt!=0: FRAME_ERR pulses, the partial word is discarded, no RX_VALID.
  - Takes priority over a same-cycle SCLK edge.
- Holding register:
  - TX_LOAD while TX_READY=1 writes hold and sets TX_READY=0.
  - TX_LOAD while TX_READY=0 is ignored.
  - TX_LOAD in the same cycle as a word load: the load consumes the old hold, then the new data is written, leaving TX_READY=0.
- Mode and edge rules: CPOL_IN/CPHA_IN changes during ACTIVE are ignored. SCLK edges while IDLE are ignored.
- Reset asserted mid-frame returns the block to reset values immediately. After reset releases, the block waits for the next SS falling edge.

Decomposition:
- Shared package spi_pkg holds:
  - FSM state encoding (IDLE, ACTIVE)
  - mode constants MODE0..MODE3
  - default DATA_W
- Natural sub-module: spi_sync_edge, which synchronizes one pin (SYNC_STAGES) and outputs the level, rise and fall pulses. It is instantiated three times.

Test Plan:
- Mode 0: TX_LOAD 0x3C, master sends 0xA5 LSB-first -> RX_DATA=0xA5 with one RX_VALID pulse; MISO bits 0,0,1,1,1,1,0,0; TX_READY returns to 1 at SS fall.
- Mode 3 (CPOL=1, CPHA=1): hold loaded with 0x81, master sends 0xFF -> RX_DATA=0xFF; MISO bit order 1,0,0,0,0,0,0,1; MISO_OE=0 and MISO=1 after SS rises.
- Two words in one SS frame (mode 1): load 0x12, then 0x34 while TX_READY=1 -> master receives 0x12 then 0x34; two RX_VALID pulses; no TX_UNDERRUN.
- Underrun: no TX_LOAD, mode 2 frame -> TX_UNDERRUN pulses once; master receives 0xFF; RX_DATA still captured correctly.
- Abort: SS rises after 5 SCLK sample edges -> FRAME_ERR pulses; RX_VALID stays 0; RX_DATA unchanged. The next full frame receives correctly.
- Reset mid-frame: RST pulsed after 3 bits -> all outputs at reset values within the same cycle. The next frame after SS toggles receives a correct byte.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spi_pkg
// Brief    : Shared types and constants for the SPI slave core: FSM state
//            encoding, SPI mode constants ({CPOL, CPHA}) and default width.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int DEFAULT_DATA_W = 8;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Brief    : Brings one asynchronous pin into the system clock domain through
//            a SYNC_STAGES flop chain (minimum 2), then a single-flop edge
//            detector producing rise/fall pulses aligned with the level output.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the pin through the chain; the edge flop trails the last stage
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_pin};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Chain resets low so a pin already low at release does not look like a fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign o_fall  = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave_core.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_core
// Brief    : Oversampled SPI slave, all four CPOL/CPHA modes, LSB first.
//            Parallel RX port with valid pulse, one-deep TX holding register.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPOL_IN,
  input  logic              CPHA_IN,
  input  logic              SCLK_IN,
  input  logic              SS_IN,
  input  logic              MOSI_IN,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_LOAD,
  output logic              TX_READY,
  output logic              MISO,
  output logic              MISO_OE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              BUSY,
  output logic              FRAME_ERR,
  output logic              TX_UNDERRUN
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(CLK), .rst(RST), .i_pin(SCLK_IN),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(CLK), .rst(RST), .i_pin(SS_IN),
    .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(CLK), .rst(RST), .i_pin(MOSI_IN),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused_sync = ^{w_sclk_level, w_ss_level, w_mosi_rise, w_mosi_fall};

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               pend_q, pend_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               tx_underrun_q, tx_underrun_d;

  logic               w_cpol, w_cpha, w_lead, w_trail, w_sample, w_shift;
  logic               w_word_load;
  logic [DATA_W-1:0]  w_rx_next;

  assign w_cpol    = (mode_q == MODE2) || (mode_q == MODE3);
  assign w_cpha    = (mode_q == MODE1) || (mode_q == MODE3);
  assign w_lead    = w_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail   = w_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample  = w_cpha ? w_trail : w_lead;
  assign w_shift   = w_cpha ? w_lead  : w_trail;
  assign w_rx_next = {w_mosi, rx_sr_q[DATA_W-1:1]};

  // Next-state, shift/sample datapath and holding-register control
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    pend_d        = pend_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    tx_underrun_d = 1'b0;
    w_word_load   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (w_ss_fall) begin
          state_d     = ST_ACTIVE;
          mode_d      = {CPOL_IN, CPHA_IN};
          bit_cnt_d   = '0;
          pend_d      = 1'b0;
          w_word_load = ~CPHA_IN;
        end
      end
      ST_ACTIVE: begin
        if (w_ss_rise) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          pend_d      = 1'b0;
          frame_err_d = (bit_cnt_q != '0);
        end else if (w_sample) begin
          rx_sr_d = w_rx_next;
          // A word boundary seen on the previous trailing edge is committed
          // only now, once the master has shown the frame really continues.
          if (pend_q) begin
            w_word_load = 1'b1;
            pend_d      = 1'b0;
          end
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            rx_data_d  = w_rx_next;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (w_shift) begin
          if (bit_cnt_q == '0 && w_cpha) begin
            w_word_load = 1'b1;
          end else if (bit_cnt_q == '0) begin
            // CPHA=0 word boundary: present the next word's first bit now
            // without consuming the holding register, since this may be the
            // last trailing edge of the frame.
            pend_d  = 1'b1;
            tx_sr_d = hold_valid_q ? hold_q : '1;
          end else begin
            tx_sr_d = {1'b1, tx_sr_q[DATA_W-1:1]};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_word_load) begin
      tx_sr_d       = hold_valid_q ? hold_q : '1;
      tx_underrun_d = ~hold_valid_q;
      hold_valid_d  = 1'b0;
    end

    // A same-cycle word load frees the register before the new write lands
    if (TX_LOAD && !hold_valid_d) begin
      hold_d       = TX_DATA;
      hold_valid_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE0;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      pend_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      pend_q        <= pend_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign BUSY        = (state_q == ST_ACTIVE);
  assign MISO_OE     = (state_q == ST_ACTIVE);
  assign MISO        = (state_q == ST_ACTIVE) ? tx_sr_q[0] : 1'b1;
  assign TX_READY    = ~hold_valid_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign FRAME_ERR   = frame_err_q;
  assign TX_UNDERRUN = tx_underrun_q;

endmodule : spi_slave_core
`default_nettype wire
